// File: rtl/dfp_scaleb_arb96_pkg.sv
// Shared DFP96 types and constants for the scaleb arbiter slice.
// Layout: sign[95], biased exponent[94:81] (all-ones = Inf/NaN), coefficient[80:0].
package dfp_scaleb_arb96_pkg;

    localparam int unsigned DFP_SCALEB_LAT = 2;
    localparam int unsigned DFP96_W        = 96;
    localparam int unsigned DFP96_EW       = 14;
    localparam int unsigned DFP96_CW       = 81;
    localparam int unsigned DFP96_EMAX     = 16382;
    localparam logic [DFP96_EW-1:0] DFP96_EXP_SPECIAL = '1;

    typedef struct packed {
        logic                sign;
        logic [DFP96_EW-1:0] exp;
        logic [DFP96_CW-1:0] coeff;
    } dfp96_t;

    // Outcome of the exponent adjustment, resolved in stage 1 of the unit
    typedef enum logic [1:0] {
        SC_NORM = 2'd0,
        SC_PASS = 2'd1,
        SC_OVF  = 2'd2,
        SC_UNF  = 2'd3
    } scl_class_e;

endpackage

// File: rtl/dfp_scaleb_arb96_if.sv
// Request/result bus between FPU issue logic and the shared DFP96 scaleb pipe.
interface dfp_scaleb_arb96_if
    import dfp_scaleb_arb96_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TAGW = 8
) ();

    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*DFP96_W-1:0] req_a;
    logic [NREQ*32-1:0]      req_b;
    logic [NREQ*TAGW-1:0]    req_tag;
    logic                    res_valid;
    logic                    res_ready;
    logic [DFP96_W-1:0]      res_o;
    logic [IW-1:0]           res_id;
    logic [TAGW-1:0]         res_tag;
    logic [1:0]              inflight;

    modport master (
        output req_valid, req_a, req_b, req_tag, res_ready,
        input  req_ready, res_valid, res_o, res_id, res_tag, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, res_ready,
        output req_ready, res_valid, res_o, res_id, res_tag, inflight
    );

endinterface

// File: rtl/DFPScaleb96.sv
// Two-stage DFP96 scaleb: exponent += b, overflow to Inf, underflow clamps exponent to 0.
// Data registers are intentionally not reset; both stages advance on ce.
module DFPScaleb96
    import dfp_scaleb_arb96_pkg::*;
(
    input  logic               clk,
    input  logic               ce,
    input  dfp96_t             a,
    input  logic signed [31:0] b,
    output dfp96_t             y
);

    localparam logic signed [33:0] EMAX_S = 34'(DFP96_EMAX);

    logic signed [33:0]  sum;
    scl_class_e          cls;
    dfp96_t              a_q;
    scl_class_e          cls_q;
    logic [DFP96_EW-1:0] exp_q;

    always_comb begin
        sum = $signed({20'd0, a.exp}) + $signed({{2{b[31]}}, b});
        cls = SC_NORM;
        if (a.exp == DFP96_EXP_SPECIAL) begin
            cls = SC_PASS;
        end else if (sum > EMAX_S) begin
            cls = SC_OVF;
        end else if (sum < 34'sd0) begin
            cls = SC_UNF;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            a_q   <= a;
            cls_q <= cls;
            exp_q <= sum[DFP96_EW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            unique case (cls_q)
                SC_PASS: y <= a_q;
                SC_OVF:  y <= '{sign: a_q.sign, exp: DFP96_EXP_SPECIAL, coeff: '0};
                SC_UNF:  y <= '{sign: a_q.sign, exp: '0, coeff: a_q.coeff};
                SC_NORM: y <= '{sign: a_q.sign, exp: exp_q, coeff: a_q.coeff};
            endcase
        end
    end

endmodule

// File: rtl/dfp_rr_arbiter.sv
// Requester arbiter: circular search from a pointer when DFP_SCALEB_ARB_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no pointer state.
module dfp_rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
`ifdef DFP_SCALEB_ARB_RR_EN
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv,
`endif
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] ptr;

`ifdef DFP_SCALEB_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    // idx stays 0 without a grant so the datapath sees slice 0 as don't-care input
    always_comb begin
        logic          found;
        logic [IW-1:0] ci;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        ci    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            ci = IW'((32'(ptr) + k) % NREQ);
            if (en && !found && req[ci]) begin
                gnt[ci] = 1'b1;
                idx     = ci;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dfp_scaleb_arb96.sv
// Shares one DFPScaleb96 among NREQ requesters; id/tag/valid ride alongside the unit pipe.
// DFP_SCALEB_ARB_RR_EN selects round-robin instead of fixed-priority arbitration.
module dfp_scaleb_arb96
    import dfp_scaleb_arb96_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TAGW = 8,
    parameter int unsigned LAT  = DFP_SCALEB_LAT
) (
    input logic              clk,
    input logic              rst,
    dfp_scaleb_arb96_if.slave bus
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [LAT:1]       v;
    logic [IW-1:0]      id  [1:LAT];
    logic [TAGW-1:0]    tag [1:LAT];
    logic               ce;
    logic               hs;
    logic [NREQ-1:0]    gnt;
    logic [IW-1:0]      gidx;
    dfp96_t             a_sel;
    logic signed [31:0] b_sel;
    logic [TAGW-1:0]    tag_sel;
    dfp96_t             y;
    logic [1:0]         cnt;

    // No bubble collapsing: any stall at the output freezes the whole pipe
    assign ce = ~v[LAT] | bus.res_ready;
    assign hs = |gnt;

    dfp_rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef DFP_SCALEB_ARB_RR_EN
        .clk (clk),
        .rst (rst),
        .adv (hs),
`endif
        .req (bus.req_valid),
        .en  (ce),
        .gnt (gnt),
        .idx (gidx)
    );

    always_comb begin
        a_sel   = bus.req_a[DFP96_W-1:0];
        b_sel   = bus.req_b[31:0];
        tag_sel = bus.req_tag[TAGW-1:0];
        for (int unsigned i = 1; i < NREQ; i++) begin
            if (gidx == IW'(i)) begin
                a_sel   = bus.req_a[i*DFP96_W +: DFP96_W];
                b_sel   = bus.req_b[i*32 +: 32];
                tag_sel = bus.req_tag[i*TAGW +: TAGW];
            end
        end
    end

    DFPScaleb96 u_unit (
        .clk (clk),
        .ce  (ce),
        .a   (a_sel),
        .b   (b_sel),
        .y   (y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int unsigned s = 1; s <= LAT; s++) begin
                id[s]  <= '0;
                tag[s] <= '0;
            end
        end else if (ce) begin
            v[1]   <= hs;
            id[1]  <= gidx;
            tag[1] <= tag_sel;
            for (int unsigned s = 2; s <= LAT; s++) begin
                v[s]   <= v[s-1];
                id[s]  <= id[s-1];
                tag[s] <= tag[s-1];
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int unsigned s = 1; s <= LAT; s++) begin
            cnt = cnt + 2'(v[s]);
        end
    end

    assign bus.req_ready = gnt;
    assign bus.res_valid = v[LAT];
    assign bus.res_id    = id[LAT];
    assign bus.res_tag   = tag[LAT];
    assign bus.res_o     = y;
    assign bus.inflight  = cnt;

endmodule
